// File: rtl/oled_pkg.sv
// Shared definitions for the fabric-side SSD1306 OLED SPI controller.
// Configuration macro: OLED_CTRL_INIT_ROM_EN enables the built-in init sequence.
package oled_pkg;

    typedef enum logic [2:0] {
        ST_RST_LOW,
        ST_RST_WAIT,
        ST_INIT,
        ST_IDLE,
        ST_SHIFT
    } state_t;

    localparam logic DC_CMD  = 1'b0;
    localparam logic DC_DATA = 1'b1;

    // SSD1306 128x64 power-up command list, sent in order with DC = command.
    localparam int INIT_LEN = 25;
    localparam logic [7:0] INIT_ROM [INIT_LEN] = '{
        8'hAE, 8'hD5, 8'h80, 8'hA8, 8'h3F, 8'hD3, 8'h00, 8'h40,
        8'h8D, 8'h14, 8'h20, 8'h00, 8'hA1, 8'hC8, 8'hDA, 8'h12,
        8'h81, 8'hCF, 8'hD9, 8'hF1, 8'hDB, 8'h40, 8'hA4, 8'hA6,
        8'hAF
    };

    // ROM lookup that returns 0 for indices past the end of the list.
    function automatic logic [7:0] initByte(input logic [4:0] idx);
        logic [7:0] b;
        b = 8'h00;
        if (idx < 5'(INIT_LEN)) begin
            b = INIT_ROM[idx];
        end
        return b;
    endfunction

endpackage

// File: rtl/oled_spi_shifter.sv
// SPI mode-0 byte serializer: MSB first, SCLK idles low, DC and SDIN only move
// while SCLK is low. One start pulse launches a byte; done pulses in the final
// SCLK-high cycle so the next owner can act on the following edge.
module oled_spi_shifter
    import oled_pkg::*;
#(
    parameter int CLK_DIV = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start_i,
    input  logic [7:0] data_i,
    input  logic       dc_i,
    output logic       busy_o,
    output logic       done_o,
    output logic       sclk_o,
    output logic       sdin_o,
    output logic       dc_o
);

    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    logic             active_q, active_d;
    logic [DIV_W-1:0] div_q, div_d;
    logic [2:0]       bit_q, bit_d;
    logic [7:0]       shreg_q, shreg_d;
    logic             sclk_q, sclk_d;
    logic             dc_q, dc_d;
    logic             tick;

    assign tick   = (div_q == DIV_W'(CLK_DIV - 1));
    assign done_o = active_q & sclk_q & tick & (bit_q == 3'd7);
    assign busy_o = active_q;
    assign sclk_o = sclk_q;
    assign sdin_o = shreg_q[7];
    assign dc_o   = dc_q;

    // Next-state logic: each half-period tick toggles SCLK; a falling edge advances the bit.
    always_comb begin
        active_d = active_q;
        div_d    = div_q;
        bit_d    = bit_q;
        shreg_d  = shreg_q;
        sclk_d   = sclk_q;
        dc_d     = dc_q;
        if (!active_q) begin
            if (start_i) begin
                active_d = 1'b1;
                div_d    = '0;
                bit_d    = 3'd0;
                shreg_d  = data_i;
                dc_d     = dc_i;
                sclk_d   = 1'b0;
            end
        end else begin
            div_d = tick ? '0 : div_q + 1'b1;
            if (tick) begin
                if (!sclk_q) begin
                    sclk_d = 1'b1;
                end else begin
                    sclk_d = 1'b0;
                    if (bit_q == 3'd7) begin
                        active_d = 1'b0;
                    end else begin
                        bit_d   = bit_q + 3'd1;
                        shreg_d = {shreg_q[6:0], 1'b0};
                    end
                end
            end
        end
    end

    // State register with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            active_q <= 1'b0;
            div_q    <= '0;
            bit_q    <= 3'd0;
            shreg_q  <= 8'h00;
            sclk_q   <= 1'b0;
            dc_q     <= DC_CMD;
        end else begin
            active_q <= active_d;
            div_q    <= div_d;
            bit_q    <= bit_d;
            shreg_q  <= shreg_d;
            sclk_q   <= sclk_d;
            dc_q     <= dc_d;
        end
    end

endmodule

// File: rtl/oled_spi_ctrl.sv
// OLED sequencer top: power-up reset pulse, optional init command stream, then
// host byte serialization through the shared SPI shifter.
// Configuration macro: OLED_CTRL_INIT_ROM_EN compiles in the INIT state.
module oled_spi_ctrl
    import oled_pkg::*;
#(
    parameter int CLK_DIV      = 4,
    parameter int RST_LOW_CYC  = 1000,
    parameter int RST_WAIT_CYC = 1000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       s_valid,
    output logic       s_ready,
    input  logic [7:0] s_data,
    input  logic       s_dc,
    input  logic       reinit,
    output logic       init_done,
    output logic       busy,
    output logic       oled_nrst,
    output logic       oled_dc,
    output logic       oled_sclk,
    output logic       oled_sdin
);

    localparam int CNT_MAX = (RST_LOW_CYC > RST_WAIT_CYC) ? RST_LOW_CYC : RST_WAIT_CYC;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             pending_q, pending_d;
    logic             init_done_q, init_done_d;
`ifdef OLED_CTRL_INIT_ROM_EN
    logic [4:0]       rom_idx_q, rom_idx_d;
`endif

    logic       shift_start;
    logic [7:0] shift_data;
    logic       shift_dc;
    logic       shift_busy;
    logic       shift_done;

    assign oled_nrst = (state_q != ST_RST_LOW);
    assign busy      = (state_q != ST_IDLE);
    assign init_done = init_done_q;

    oled_spi_shifter #(
        .CLK_DIV (CLK_DIV)
    ) u_shifter (
        .clk     (clk),
        .rst_n   (rst_n),
        .start_i (shift_start),
        .data_i  (shift_data),
        .dc_i    (shift_dc),
        .busy_o  (shift_busy),
        .done_o  (shift_done),
        .sclk_o  (oled_sclk),
        .sdin_o  (oled_sdin),
        .dc_o    (oled_dc)
    );

    // Sequencer: reset timing, init streaming, host handshake and deferred reinit.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        pending_d   = pending_q;
        init_done_d = init_done_q;
        shift_start = 1'b0;
        shift_data  = s_data;
        shift_dc    = s_dc;
        s_ready     = 1'b0;
`ifdef OLED_CTRL_INIT_ROM_EN
        rom_idx_d   = rom_idx_q;
`endif
        case (state_q)
            ST_RST_LOW: begin
                init_done_d = 1'b0;
                pending_d   = 1'b0;
                if (cnt_q == CNT_W'(RST_LOW_CYC - 1)) begin
                    cnt_d   = '0;
                    state_d = ST_RST_WAIT;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_RST_WAIT: begin
                if (cnt_q == CNT_W'(RST_WAIT_CYC - 1)) begin
                    cnt_d = '0;
`ifdef OLED_CTRL_INIT_ROM_EN
                    state_d   = ST_INIT;
                    rom_idx_d = 5'd0;
`else
                    state_d     = ST_IDLE;
                    init_done_d = 1'b1;
`endif
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
`ifdef OLED_CTRL_INIT_ROM_EN
            ST_INIT: begin
                shift_data = initByte(rom_idx_q);
                shift_dc   = DC_CMD;
                if (reinit) begin
                    pending_d = 1'b1;
                end
                if (shift_done) begin
                    if (pending_q || reinit) begin
                        state_d = ST_RST_LOW;
                    end else if (rom_idx_q == 5'(INIT_LEN)) begin
                        state_d     = ST_IDLE;
                        init_done_d = 1'b1;
                    end
                end else if (!shift_busy) begin
                    if (pending_q || reinit) begin
                        state_d = ST_RST_LOW;
                    end else begin
                        shift_start = 1'b1;
                        rom_idx_d   = rom_idx_q + 5'd1;
                    end
                end
            end
`endif
            ST_IDLE: begin
                s_ready = !reinit && !shift_busy;
                if (reinit) begin
                    state_d     = ST_RST_LOW;
                    init_done_d = 1'b0;
                end else if (s_valid && !shift_busy) begin
                    shift_start = 1'b1;
                    state_d     = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                if (reinit) begin
                    pending_d = 1'b1;
                end
                if (shift_done) begin
                    if (pending_q || reinit) begin
                        state_d     = ST_RST_LOW;
                        init_done_d = 1'b0;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: begin
                state_d     = ST_RST_LOW;
                cnt_d       = '0;
                init_done_d = 1'b0;
            end
        endcase
    end

    // Control registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= ST_RST_LOW;
            cnt_q       <= '0;
            pending_q   <= 1'b0;
            init_done_q <= 1'b0;
`ifdef OLED_CTRL_INIT_ROM_EN
            rom_idx_q   <= 5'd0;
`endif
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            pending_q   <= pending_d;
            init_done_q <= init_done_d;
`ifdef OLED_CTRL_INIT_ROM_EN
            rom_idx_q   <= rom_idx_d;
`endif
        end
    end

endmodule

// File: tb/tb_oled_spi_ctrl.sv
// Directed self-checking bench for oled_spi_ctrl.
// Honours OLED_CTRL_INIT_ROM_EN: when defined, the init byte stream is checked.
module tb_oled_spi_ctrl;

`ifdef OLED_CTRL_INIT_ROM_EN
    localparam int DIV = 1;
`else
    localparam int DIV = 2;
`endif
    localparam int LOWC  = 10;
    localparam int WAITC = 5;
    localparam int PER   = 16 * DIV + 1;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       s_valid;
    logic       s_ready;
    logic [7:0] s_data;
    logic       s_dc;
    logic       reinit;
    logic       init_done;
    logic       busy;
    logic       oled_nrst;
    logic       oled_dc;
    logic       oled_sclk;
    logic       oled_sdin;

    int total = 0;
    int bad   = 0;

    oled_spi_ctrl #(
        .CLK_DIV      (DIV),
        .RST_LOW_CYC  (LOWC),
        .RST_WAIT_CYC (WAITC)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .s_valid   (s_valid),
        .s_ready   (s_ready),
        .s_data    (s_data),
        .s_dc      (s_dc),
        .reinit    (reinit),
        .init_done (init_done),
        .busy      (busy),
        .oled_nrst (oled_nrst),
        .oled_dc   (oled_dc),
        .oled_sclk (oled_sclk),
        .oled_sdin (oled_sdin)
    );

    // Free-running clock.
    always #5 clk = ~clk;

    // Cycle counter used to time handshakes and NRST edges.
    int cycleCnt = 0;
    always @(posedge clk) cycleCnt <= cycleCnt + 1;

    // SPI monitor: samples SDIN/DC whenever SCLK is seen newly high, assembles bytes.
    logic       prevSclk = 1'b0;
    int         sclkRises = 0;
    int         monBits = 0;
    logic [7:0] monShift = 8'h00;
    logic       monDcFirst = 1'b0;
    logic       monMixed = 1'b0;
    logic [7:0] monBytes [$];
    logic       monDcs [$];
    logic       monMixedQ [$];
    always @(negedge clk) begin
        if (oled_sclk === 1'b1 && prevSclk === 1'b0) begin
            sclkRises = sclkRises + 1;
            if (monBits == 0) begin
                monDcFirst = oled_dc;
                monMixed   = 1'b0;
            end else if (oled_dc !== monDcFirst) begin
                monMixed = 1'b1;
            end
            monShift = {monShift[6:0], oled_sdin};
            monBits  = monBits + 1;
            if (monBits == 8) begin
                monBytes.push_back(monShift);
                monDcs.push_back(monDcFirst);
                monMixedQ.push_back(monMixed);
                monBits = 0;
            end
        end
        if (oled_nrst === 1'b0) monBits = 0;
        prevSclk = oled_sclk;
    end

    // Hard time limit so a stuck design still ends the run.
    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout required finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total = total + 1;
        assert (obs === exp) else begin
            bad = bad + 1;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus(input logic [7:0] data, input logic dc);
        s_valid = 1'b1;
        s_data  = data;
        s_dc    = dc;
    endtask

    task automatic checkResetValues(input string tag);
        checkOutput({tag, "_nrst"},  oled_nrst, 0);
        checkOutput({tag, "_sclk"},  oled_sclk, 0);
        checkOutput({tag, "_sdin"},  oled_sdin, 0);
        checkOutput({tag, "_dc"},    oled_dc,   0);
        checkOutput({tag, "_ready"}, s_ready,   0);
        checkOutput({tag, "_done"},  init_done, 0);
        checkOutput({tag, "_busy"},  busy,      1);
    endtask

    task automatic waitInitDone(input string tag);
        int k;
        k = 0;
        while (init_done !== 1'b1 && k < 3000) begin
            @(negedge clk);
            k++;
        end
        checkOutput(tag, init_done, 1);
    endtask

    task automatic waitReady(input string tag);
        int k;
        k = 0;
        while (s_ready !== 1'b1 && k < 200) begin
            @(negedge clk);
            k++;
        end
        checkOutput(tag, s_ready, 1);
    endtask

    logic [7:0] expRom [25] = '{
        8'hAE, 8'hD5, 8'h80, 8'hA8, 8'h3F, 8'hD3, 8'h00, 8'h40,
        8'h8D, 8'h14, 8'h20, 8'h00, 8'hA1, 8'hC8, 8'hDA, 8'h12,
        8'h81, 8'hCF, 8'hD9, 8'hF1, 8'hDB, 8'h40, 8'hA4, 8'hA6,
        8'hAF
    };
    logic [7:0] strData [3] = '{8'h00, 8'hFF, 8'h81};
    logic       strDc   [3] = '{1'b1, 1'b1, 1'b0};

    // Directed sequence: reset, init, single byte, streamed bytes, reinit, reset mid-byte.
    initial begin
        int n;
        int t0;
        int base;
        int rises0;
        int hs [3];
        logic dcBefore;

        rst_n   = 1'b0;
        s_valid = 1'b0;
        s_data  = 8'h00;
        s_dc    = 1'b0;
        reinit  = 1'b0;
        repeat (3) @(negedge clk);
        checkResetValues("por");

        rises0 = sclkRises;
        base   = monBytes.size();
        rst_n  = 1'b1;
        n = 0;
        while (oled_nrst === 1'b0 && n < 100) begin
            n++;
            @(negedge clk);
        end
        checkOutput("nrst_low_cycles", n, LOWC);

`ifdef OLED_CTRL_INIT_ROM_EN
        waitInitDone("init_seq_done");
        checkOutput("init_byte_count", monBytes.size() - base, 25);
        for (int i = 0; i < 25; i++) begin
            checkOutput($sformatf("init_byte%0d", i), monBytes[base + i], expRom[i]);
            checkOutput($sformatf("init_dc%0d", i), monDcs[base + i], 0);
        end
`else
        n = 0;
        while (init_done !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        checkOutput("nrst_to_init_done", n, WAITC);
        checkOutput("reset_no_sclk", sclkRises - rises0, 0);
`endif
        checkOutput("idle_busy", busy, 0);
        checkOutput("idle_ready", s_ready, 1);

        // Single data byte 0xA5.
        base = monBytes.size();
        applyStimulus(8'hA5, 1'b1);
        checkOutput("a5_ready_at_T", s_ready, 1);
        t0 = cycleCnt;
        @(negedge clk);
        s_valid = 1'b0;
        checkOutput("a5_ready_low", s_ready, 0);
        checkOutput("a5_dc_T1", oled_dc, 1);
        checkOutput("a5_msb_T1", oled_sdin, 1);
        checkOutput("a5_sclk_T1", oled_sclk, 0);
        waitReady("a5_ready_back");
        checkOutput("a5_ready_cycle", cycleCnt - t0, PER);
        checkOutput("a5_count", monBytes.size() - base, 1);
        checkOutput("a5_byte", monBytes[base], 8'hA5);
        checkOutput("a5_dc", monDcs[base], 1);
        checkOutput("a5_dc_stable", monMixedQ[base], 0);

        // Three bytes with s_valid held high.
        base = monBytes.size();
        dcBefore = 1'b0;
        for (int i = 0; i < 3; i++) begin
            applyStimulus(strData[i], strDc[i]);
            waitReady($sformatf("str_ready%0d", i));
            hs[i] = cycleCnt;
            if (i == 2) dcBefore = oled_dc;
            @(negedge clk);
        end
        s_valid = 1'b0;
        checkOutput("str_dc_before_b3", dcBefore, 1);
        checkOutput("str_dc_after_b3", oled_dc, 0);
        checkOutput("str_sclk_after_b3", oled_sclk, 0);
        checkOutput("str_period01", hs[1] - hs[0], PER);
        checkOutput("str_period12", hs[2] - hs[1], PER);
        waitReady("str_ready_end");
        checkOutput("str_count", monBytes.size() - base, 3);
        for (int i = 0; i < 3; i++) begin
            checkOutput($sformatf("str_byte%0d", i), monBytes[base + i], strData[i]);
            checkOutput($sformatf("str_dc%0d", i), monDcs[base + i], strDc[i]);
            checkOutput($sformatf("str_dcstable%0d", i), monMixedQ[base + i], 0);
        end

        // reinit pulsed while a byte is on the wire.
        base = monBytes.size();
        applyStimulus(8'h3C, 1'b1);
        t0 = cycleCnt;
        @(negedge clk);
        s_valid = 1'b0;
        repeat (6) @(negedge clk);
        reinit = 1'b1;
        @(negedge clk);
        reinit = 1'b0;
        checkOutput("reinit_still_busy", busy, 1);
        checkOutput("reinit_done_held", init_done, 1);
        n = 0;
        while (oled_nrst !== 1'b0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        checkOutput("reinit_nrst_cycle", cycleCnt - t0, PER);
        checkOutput("reinit_done_drop", init_done, 0);
        checkOutput("reinit_ready_low", s_ready, 0);
        checkOutput("reinit_byte", monBytes[base], 8'h3C);
        waitInitDone("reinit_restart_done");

        // rst_n asserted mid-byte.
        applyStimulus(8'hF0, 1'b1);
        @(negedge clk);
        s_valid = 1'b0;
        checkOutput("rstmid_sdin", oled_sdin, 1);
        checkOutput("rstmid_dc", oled_dc, 1);
        repeat (4) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        checkResetValues("rstmid");
        rises0 = sclkRises;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        n = 0;
        while (oled_nrst !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        checkOutput("rstmid_no_sclk", sclkRises - rises0, 0);
        waitInitDone("rstmid_restart_done");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
